// File: rtl/fpu_mult_ctrl.sv
// Register-mapped control front end for the pipelined FP32 multiplier.
// Holds the operands, issues one valid_in pulse per operation and captures the result or a timeout.
module fpu_mult_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  addr,
  input  logic [31:0] data_in,
  input  logic        data_write,
  input  logic        data_read,
  output logic [31:0] data_out,
  output logic        irq,
  output logic        mul_valid_in,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_valid_out,
  input  logic [31:0] mul_result
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [31:0]      result;
  logic             auto_mode;
  logic             irq_en;
  logic             done;
  logic             err;

  logic wr_op_a;
  logic wr_op_b;
  logic wr_ctrl;
  logic rd_result;
  logic busy;
  logic start_req;

  always_comb begin
    wr_op_a   = data_write && (addr == 4'h0);
    wr_op_b   = data_write && (addr == 4'h4);
    wr_ctrl   = data_write && (addr == 4'h8);
    rd_result = data_read  && (addr == 4'hC);
    busy      = (state != IDLE);
    start_req = (wr_ctrl && data_in[0]) || (auto_mode && wr_op_b);
  end

  always_comb begin
    data_out = '0;
    case (addr)
      4'h0:    data_out = op_a;
      4'h4:    data_out = op_b;
      4'h8:    data_out = {26'b0, err, done, 1'b0, irq_en, auto_mode, busy};
      4'hC:    data_out = result;
      default: data_out = '0;
    endcase
  end

  assign irq   = irq_en && (done || err);
  assign mul_a = op_a;
  assign mul_b = op_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      result       <= '0;
      auto_mode    <= 1'b0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mul_valid_in <= 1'b0;
    end else begin
      mul_valid_in <= 1'b0;

      // Mode bits stay writable in flight; everything else is gated by state below.
      if (wr_ctrl) begin
        auto_mode <= data_in[1];
        irq_en    <= data_in[2];
      end

      // Placed before the FSM so a DONE set by a capture in the same cycle wins.
      if (rd_result) begin
        done <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (wr_op_a) begin
            op_a <= data_in;
          end
          if (wr_op_b) begin
            op_b <= data_in;
          end
          if (wr_ctrl && data_in[3]) begin
            done <= 1'b0;
            err  <= 1'b0;
          end
          if (start_req) begin
            state        <= ISSUE;
            mul_valid_in <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
          end
        end

        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (mul_valid_out) begin
            result <= mul_result;
            done   <= 1'b1;
            state  <= IDLE;
          end else if (cnt == TIMEOUT_CNT) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mult_ctrl.sv
// Directed bench for fpu_mult_ctrl: a vector table of multiply transactions plus
// hand-written sequences for AUTO issue, timeout, writes in flight, stray results and reset.
module tb_fpu_mult_ctrl;

  localparam int unsigned TO = 15;

  logic        clk;
  logic        rst_n;
  logic [3:0]  addr;
  logic [31:0] data_in;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_out;
  logic        irq;
  logic        mul_valid_in;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_valid_out;
  logic [31:0] mul_result;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  fpu_mult_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr          (addr),
    .data_in       (data_in),
    .data_write    (data_write),
    .data_read     (data_read),
    .data_out      (data_out),
    .irq           (irq),
    .mul_valid_in  (mul_valid_in),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_valid_out (mul_valid_out),
    .mul_result    (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mul_valid_in === 1'b1) pulse_cnt++;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    int unsigned lat;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0; data_in = '0;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; data_read = 1'b1;
    #1 d = data_out;
    @(negedge clk);
    data_read = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    addr = a;
    #1 d = data_out;
  endtask

  logic [31:0] rd;
  int pc0;

  initial begin
    vecs[0] = '{a: 32'h40000000, b: 32'h40400000, prod: 32'h40C00000, lat: 3};
    vecs[1] = '{a: 32'h3F800000, b: 32'hC0000000, prod: 32'hC0000000, lat: 1};
    vecs[2] = '{a: 32'h3FC00000, b: 32'h40200000, prod: 32'h40700000, lat: TO + 1};
    vecs[3] = '{a: 32'h3F000000, b: 32'h40800000, prod: 32'h40000000, lat: 2};

    rst_n = 1'b0; addr = '0; data_in = '0; data_write = 1'b0; data_read = 1'b0;
    mul_valid_out = 1'b0; mul_result = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    peek(4'h0, rd); check("rst_op_a", rd, 32'h0);
    peek(4'h4, rd); check("rst_op_b", rd, 32'h0);
    peek(4'h8, rd); check("rst_ctrl", rd, 32'h0);
    peek(4'hC, rd); check("rst_result", rd, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_valid_in", {31'b0, mul_valid_in}, 32'h0);
    peek(4'h2, rd); check("unmapped_read", rd, 32'h0);

    // Table: START|IRQ_EN, stub answers in WAIT cycle `lat` (lat = TO+1 is the last counter value)
    for (int i = 0; i < 4; i++) begin
      bus_write(4'h0, vecs[i].a);
      bus_write(4'h4, vecs[i].b);
      bus_write(4'h8, 32'h5);
      check($sformatf("v%0d_pulse", i), {31'b0, mul_valid_in}, 32'h1);
      check($sformatf("v%0d_mul_a", i), mul_a, vecs[i].a);
      check($sformatf("v%0d_mul_b", i), mul_b, vecs[i].b);
      for (int c = 1; c <= int'(vecs[i].lat); c++) begin
        @(negedge clk);
        if (c == 1) check($sformatf("v%0d_pulse_end", i), {31'b0, mul_valid_in}, 32'h0);
        peek(4'h8, rd);
        check($sformatf("v%0d_busy_c%0d", i, c), {31'b0, rd[0]}, 32'h1);
      end
      mul_valid_out = 1'b1; mul_result = vecs[i].prod;
      @(negedge clk);
      mul_valid_out = 1'b0; mul_result = '0;
      peek(4'h8, rd); check($sformatf("v%0d_ctrl_done", i), rd, 32'h14);
      check($sformatf("v%0d_irq", i), {31'b0, irq}, 32'h1);
      read_reg(4'hC, rd); check($sformatf("v%0d_result", i), rd, vecs[i].prod);
      peek(4'h8, rd); check($sformatf("v%0d_ctrl_rdclr", i), rd, 32'h04);
      check($sformatf("v%0d_irq_clr", i), {31'b0, irq}, 32'h0);
    end

    // AUTO: issue fires on the OP_B write
    bus_write(4'h8, 32'h2);
    bus_write(4'h0, 32'h3F800000);
    check("auto_no_issue_op_a", {31'b0, mul_valid_in}, 32'h0);
    bus_write(4'h4, 32'hC0000000);
    check("auto_issue", {31'b0, mul_valid_in}, 32'h1);
    check("auto_mul_b", mul_b, 32'hC0000000);
    repeat (2) @(negedge clk);
    mul_valid_out = 1'b1; mul_result = 32'hC0000000;
    @(negedge clk);
    mul_valid_out = 1'b0;
    peek(4'hC, rd); check("auto_result", rd, 32'hC0000000);
    peek(4'h8, rd); check("auto_ctrl", rd, 32'h12);
    check("auto_irq_off", {31'b0, irq}, 32'h0);
    bus_write(4'h8, 32'h0);

    // Timeout: busy for exactly TO+1 WAIT cycles, then ERR
    bus_write(4'h8, 32'h1);
    check("to_pulse", {31'b0, mul_valid_in}, 32'h1);
    peek(4'h8, rd); check("to_done_cleared", rd, 32'h1);
    for (int c = 1; c <= int'(TO) + 1; c++) begin
      @(negedge clk);
      peek(4'h8, rd);
      check($sformatf("to_busy_c%0d", c), {31'b0, rd[0]}, 32'h1);
    end
    @(negedge clk);
    peek(4'h8, rd); check("to_ctrl_err", rd, 32'h20);
    peek(4'hC, rd); check("to_result_kept", rd, 32'hC0000000);
    bus_write(4'h8, 32'h4);
    check("to_irq_err", {31'b0, irq}, 32'h1);
    bus_write(4'h8, 32'hC);
    peek(4'h8, rd); check("to_clr", rd, 32'h04);
    check("to_irq_clr", {31'b0, irq}, 32'h0);

    // Writes while busy, capture coinciding with a write, stray result in IDLE
    bus_write(4'h0, 32'h40000000);
    bus_write(4'h4, 32'h40400000);
    pc0 = pulse_cnt;
    bus_write(4'h8, 32'h1);
    bus_write(4'h0, 32'hFFFFFFFF);
    bus_write(4'h8, 32'h1);
    peek(4'h0, rd); check("busy_op_a_kept", rd, 32'h40000000);
    check("busy_mul_a", mul_a, 32'h40000000);
    @(negedge clk);
    mul_valid_out = 1'b1; mul_result = 32'h40C00000;
    addr = 4'h4; data_in = 32'h12345678; data_write = 1'b1;
    @(negedge clk);
    mul_valid_out = 1'b0; data_write = 1'b0;
    peek(4'hC, rd); check("cap_result", rd, 32'h40C00000);
    peek(4'h4, rd); check("cap_op_b_kept", rd, 32'h40400000);
    peek(4'h8, rd); check("cap_ctrl", rd, 32'h10);
    check("busy_single_pulse", pulse_cnt - pc0, 32'd1);
    read_reg(4'hC, rd);
    @(negedge clk);
    mul_valid_out = 1'b1; mul_result = 32'hDEADBEEF;
    @(negedge clk);
    mul_valid_out = 1'b0;
    peek(4'hC, rd); check("stray_result", rd, 32'h40C00000);
    peek(4'h8, rd); check("stray_ctrl", rd, 32'h0);

    // Reset during ISSUE
    pc0 = pulse_cnt;
    bus_write(4'h8, 32'h5);
    check("rst_mid_pulse", {31'b0, mul_valid_in}, 32'h1);
    rst_n = 1'b0;
    #1 check("rst_mid_valid_drop", {31'b0, mul_valid_in}, 32'h0);
    peek(4'h0, rd); check("rst_mid_op_a", rd, 32'h0);
    peek(4'h4, rd); check("rst_mid_op_b", rd, 32'h0);
    peek(4'h8, rd); check("rst_mid_ctrl", rd, 32'h0);
    peek(4'hC, rd); check("rst_mid_result", rd, 32'h0);
    check("rst_mid_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mul_valid_out = 1'b1; mul_result = 32'h3F800000;
    @(negedge clk);
    mul_valid_out = 1'b0;
    peek(4'hC, rd); check("post_rst_result", rd, 32'h0);
    peek(4'h8, rd); check("post_rst_ctrl", rd, 32'h0);
    check("post_rst_no_pulse", pulse_cnt - pc0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
